// File: rtl/div_hilo_ctrl.sv
// Execute-stage divide controller: issues DIV/DIVU to a multi-cycle divider, stalls the
// pipeline until its result is ready, handles annul on flush, and owns the HI/LO registers.
module div_hilo_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_div_i,
  input  logic               op_divu_i,
  input  logic               op_mthi_i,
  input  logic               op_mtlo_i,
  input  logic [WIDTH-1:0]   reg1_i,
  input  logic [WIDTH-1:0]   reg2_i,
  input  logic               hold_i,
  input  logic               flush_i,
  output logic               div_start_o,
  output logic               div_annul_o,
  output logic               div_signed_o,
  output logic [WIDTH-1:0]   div_opdata1_o,
  output logic [WIDTH-1:0]   div_opdata2_o,
  input  logic [2*WIDTH-1:0] div_result_i,
  input  logic               div_ready_i,
  output logic               stallreq_o,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
  logic             signed_q, signed_d;
  logic             is_div;

  assign is_div = op_div_i | op_divu_i;

  always_comb begin
    state_d       = state_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    op1_d         = op1_q;
    op2_d         = op2_q;
    signed_d      = signed_q;
    div_start_o   = 1'b0;
    div_annul_o   = 1'b0;
    stallreq_o    = 1'b0;
    div_signed_o  = signed_q;
    div_opdata1_o = op1_q;
    div_opdata2_o = op2_q;

    unique case (state_q)
      StIdle: begin
        if (is_div && !flush_i) begin
          // Issue cycle: divider sees operands straight from EX, latched for later cycles.
          div_start_o   = 1'b1;
          stallreq_o    = 1'b1;
          div_signed_o  = op_div_i;
          div_opdata1_o = reg1_i;
          div_opdata2_o = reg2_i;
          op1_d         = reg1_i;
          op2_d         = reg2_i;
          signed_d      = op_div_i;
          state_d       = StBusy;
        end else if (!flush_i && !hold_i) begin
          if (op_mthi_i) hi_d = reg1_i;
          if (op_mtlo_i) lo_d = reg1_i;
        end
      end
      StBusy: begin
        if (flush_i) begin
          div_annul_o = 1'b1;
          state_d     = StIdle;
        end else if (div_ready_i) begin
          hi_d    = div_result_i[2*WIDTH-1:WIDTH];
          lo_d    = div_result_i[WIDTH-1:0];
          state_d = hold_i ? StDone : StIdle;
        end else begin
          div_start_o = 1'b1;
          stallreq_o  = 1'b1;
        end
      end
      StDone: begin
        // Finished DIV still sits in EX; wait for it to move on without re-issuing.
        if (!hold_i || flush_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      hi_q     <= '0;
      lo_q     <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      signed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      signed_q <= signed_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Randomized self-checking bench for div_hilo_ctrl; the bench plays the divider and keeps
// an architectural HI/LO model computed with plain arithmetic.
module tb_div_hilo_ctrl;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           op_div, op_divu, op_mthi, op_mtlo;
  logic [W-1:0]   reg1, reg2;
  logic           hold, flush;
  logic           div_start, div_annul, div_signed;
  logic [W-1:0]   div_opdata1, div_opdata2;
  logic [2*W-1:0] div_result;
  logic           div_ready;
  logic           stallreq;
  logic [W-1:0]   hi, lo;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] hi_m, lo_m;

  div_hilo_ctrl #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .op_div_i      (op_div),
    .op_divu_i     (op_divu),
    .op_mthi_i     (op_mthi),
    .op_mtlo_i     (op_mtlo),
    .reg1_i        (reg1),
    .reg2_i        (reg2),
    .hold_i        (hold),
    .flush_i       (flush),
    .div_start_o   (div_start),
    .div_annul_o   (div_annul),
    .div_signed_o  (div_signed),
    .div_opdata1_o (div_opdata1),
    .div_opdata2_o (div_opdata2),
    .div_result_i  (div_result),
    .div_ready_i   (div_ready),
    .stallreq_o    (stallreq),
    .hi_o          (hi),
    .lo_o          (lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    op_div     = 1'b0;
    op_divu    = 1'b0;
    op_mthi    = 1'b0;
    op_mtlo    = 1'b0;
    hold       = 1'b0;
    flush      = 1'b0;
    div_ready  = 1'b0;
    reg1       = $urandom;
    reg2       = $urandom;
    div_result = {$urandom, $urandom};
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, ".start"}, div_start, 1'b0);
    check_eq({tag, ".stall"}, stallreq, 1'b0);
    check_eq({tag, ".annul"}, div_annul, 1'b0);
    check_eq({tag, ".hi"}, hi, hi_m);
    check_eq({tag, ".lo"}, lo, lo_m);
  endtask

  // One idle cycle after every operation, confirming the architectural state.
  task automatic trailer();
    @(negedge clk);
    idle_inputs();
    #1;
    check_quiet("idle");
  endtask

  // Full divide transaction. lat = BUSY cycles until ready; flush_at/rst_at abort on that BUSY
  // cycle (0 = never); hold_n = cycles held in EX after the result arrives.
  task automatic do_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int lat, input int flush_at, input int rst_at, input int hold_n);
    logic [W-1:0] q, r;
    if (b == '0) begin
      q = '0;
      r = '0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end

    @(negedge clk);
    idle_inputs();
    op_div  = sgn;
    op_divu = !sgn;
    reg1    = a;
    reg2    = b;
    #1;
    check_eq("issue.start", div_start, 1'b1);
    check_eq("issue.stall", stallreq, 1'b1);
    check_eq("issue.op1", div_opdata1, a);
    check_eq("issue.op2", div_opdata2, b);
    check_eq("issue.signed", div_signed, sgn);
    @(posedge clk);

    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      idle_inputs();
      // Instruction stays in EX; sometimes swap in a stray MTHI/MTLO strobe instead.
      case ($urandom_range(0, 3))
        0:       op_mthi = 1'b1;
        1:       op_mtlo = 1'b1;
        default: begin op_div = sgn; op_divu = !sgn; end
      endcase
      if (i == rst_at) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        hi_m = '0;
        lo_m = '0;
        #1;
        check_quiet("rst");
        check_eq("rst.signed", div_signed, 1'b0);
        check_eq("rst.op1", div_opdata1, '0);
        return;
      end
      #1;
      check_eq("busy.op1", div_opdata1, a);
      check_eq("busy.op2", div_opdata2, b);
      check_eq("busy.signed", div_signed, sgn);
      check_eq("busy.hi", hi, hi_m);
      check_eq("busy.lo", lo, lo_m);
      if (i == flush_at) begin
        flush     = 1'b1;
        div_ready = $urandom_range(0, 1);
        div_result = {r, q};
        #1;
        check_eq("flush.annul", div_annul, 1'b1);
        check_eq("flush.start", div_start, 1'b0);
        check_eq("flush.stall", stallreq, 1'b0);
        @(posedge clk);
        trailer();
        return;
      end else if (i == lat) begin
        div_ready  = 1'b1;
        div_result = {r, q};
        hold       = (hold_n > 0);
        #1;
        check_eq("ready.start", div_start, 1'b0);
        check_eq("ready.stall", stallreq, 1'b0);
        check_eq("ready.annul", div_annul, 1'b0);
      end else begin
        hold = $urandom_range(0, 1);
        #1;
        check_eq("busy.start", div_start, 1'b1);
        check_eq("busy.stall", stallreq, 1'b1);
        check_eq("busy.annul", div_annul, 1'b0);
      end
      @(posedge clk);
    end
    hi_m = r;
    lo_m = q;

    if (hold_n > 0) begin
      for (int j = 0; j <= hold_n; j++) begin
        @(negedge clk);
        idle_inputs();
        op_div     = sgn;
        op_divu    = !sgn;
        reg1       = a;
        reg2       = b;
        div_ready  = 1'b1;   // stray ready must not cause a second write
        hold       = (j < hold_n);
        flush      = (j == hold_n) && ($urandom_range(0, 1) == 1);
        if (flush) hold = 1'b1;
        #1;
        check_quiet("done");
        @(posedge clk);
      end
    end
    trailer();
  endtask

  task automatic do_mt(input bit to_hi, input logic [W-1:0] v, input bit h, input bit f);
    @(negedge clk);
    idle_inputs();
    op_mthi = to_hi;
    op_mtlo = !to_hi;
    reg1    = v;
    hold    = h;
    flush   = f;
    #1;
    check_quiet("mt");
    @(posedge clk);
    if (!h && !f) begin
      if (to_hi) hi_m = v;
      else       lo_m = v;
    end
    trailer();
  endtask

  task automatic do_div_flushed_in_idle();
    @(negedge clk);
    idle_inputs();
    op_div = 1'b1;
    flush  = 1'b1;
    #1;
    check_quiet("idleflush");
    @(posedge clk);
    trailer();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    hi_m = '0;
    lo_m = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_quiet("reset");
    check_eq("reset.signed", div_signed, 1'b0);
    check_eq("reset.op1", div_opdata1, '0);
    check_eq("reset.op2", div_opdata2, '0);

    // Directed cases
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 8, 0, 0, 0);
    check_eq("div_m7_2.hi", hi, 32'hFFFF_FFFF);
    check_eq("div_m7_2.lo", lo, 32'hFFFF_FFFD);
    do_div(1'b0, 32'hFFFF_FFFF, 32'h10, 6, 0, 0, 0);
    check_eq("divu.hi", hi, 32'h0000_000F);
    check_eq("divu.lo", lo, 32'h0FFF_FFFF);
    do_div(1'b1, 32'd100, 32'd7, 14, 10, 0, 0);
    check_eq("flushed.hi", hi, 32'h0000_000F);
    do_div(1'b1, 32'd100, 32'd7, 5, 0, 0, 3);
    check_eq("held.lo", lo, 32'd14);
    do_div(1'b0, 32'd55, 32'd0, 3, 0, 0, 0);
    do_div_flushed_in_idle();
    do_mt(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    do_mt(1'b0, 32'hCAFE_BABE, 1'b1, 1'b0);
    check_eq("mtlo_held.lo", lo, 32'd0);
    do_mt(1'b0, 32'hCAFE_BABE, 1'b0, 1'b0);
    check_eq("mthi.hi", hi, 32'h1234_5678);
    check_eq("mtlo.lo", lo, 32'hCAFE_BABE);
    do_div(1'b1, 32'd1000, 32'd3, 9, 0, 5, 0);

    // Randomized mix
    for (int n = 0; n < 60; n++) begin
      int kind;
      logic [W-1:0] a, b;
      kind = $urandom_range(0, 9);
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? '0 : (($urandom_range(0, 1) == 1) ? $urandom : W'($urandom_range(1, 300)));
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      if (kind < 6) begin
        do_div(kind[0], a, b, $urandom_range(1, 12),
               ($urandom_range(0, 4) == 0) ? $urandom_range(1, 12) : 0,
               0,
               ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
      end else if (kind < 9) begin
        do_mt(kind[0], a, ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0));
      end else begin
        do_div_flushed_in_idle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_hilo_ctrl.md
Name: div_hilo_ctrl

Overview:
- Execute-stage controller placed between the EX ALU decode and the multi-cycle divider.
- Issues DIV/DIVU to the divider and holds the operands stable for the whole operation.
- Stalls the pipeline until the divider reports its result, and handles flushes (annul).
- Owns the HI/LO architectural registers, written by divide results and by MTHI/MTLO.

Parameters:
WIDTH, 32, operand and HI/LO register width (divider result is 2*WIDTH)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, synchronous, active-high
op_div_i  in  1  signed DIV in EX this cycle
op_divu_i  in  1  unsigned DIVU in EX this cycle
op_mthi_i  in  1  MTHI in EX this cycle
op_mtlo_i  in  1  MTLO in EX this cycle
reg1_i  in  WIDTH  rs operand (dividend / MTHI/MTLO source)
reg2_i  in  WIDTH  rt operand (divisor)
hold_i  in  1  EX held by another stall source; instruction stays in EX
flush_i  in  1  pipeline flush; EX instruction is cancelled
div_start_o  out  1  start request to divider
div_annul_o  out  1  abort request to divider
div_signed_o  out  1  signed-division select to divider
div_opdata1_o  out  WIDTH  dividend to divider
div_opdata2_o  out  WIDTH  divisor to divider
div_result_i  in  2*WIDTH  divider result: {remainder, quotient}
div_ready_i  in  1  divider result valid
stallreq_o  out  1  stall request to pipeline control
hi_o  out  WIDTH  current HI register
lo_o  out  WIDTH  current LO register

Behaviour:
- Reset (rst=1 at an edge): state IDLE; HI=0; LO=0; operand/sign latches=0. While in IDLE after reset, all control outputs are 0. Reset mid-operation returns to IDLE with no annul pulse (the divider shares rst).
- States: IDLE, BUSY, DONE.
- IDLE, with div = op_div_i|op_divu_i, !flush_i:
  - Combinationally: div_start_o=1, stallreq_o=1.
  - div_opdata1_o/div_opdata2_o/div_signed_o driven directly from reg1_i/reg2_i/op_div_i.
  - At the edge: latch these three values and go BUSY.
- IDLE with div and flush_i: no start, stay IDLE.
- BUSY: div_start_o=1; operands and signedness driven from the latches, constant until exit.
  - flush_i=1 (priority over ready): div_annul_o=1, div_start_o=0, stallreq_o=0, HI/LO unchanged, next IDLE.
  - div_ready_i=1: div_start_o=0 in the same cycle, stallreq_o=0.
    - At the edge: HI<=div_result_i[2W-1:W], LO<=div_result_i[W-1:0].
    - Next state DONE if hold_i, else IDLE.
  - Otherwise: stallreq_o=1, remain BUSY.
- DONE: the same DIV remains in EX because of hold_i.
  - div_start_o=0, stallreq_o=0; no re-issue and no second HI/LO write.
  - Leave to IDLE when hold_i=0 or flush_i=1.
- Latency: stallreq_o is high from the issue cycle through the last non-ready BUSY cycle. The controller adds zero cycles beyond the divider; the new HI/LO is visible on hi_o/lo_o the cycle after ready.
- MTHI/MTLO: accepted only in IDLE with !flush_i && !hold_i.
  - At the edge: HI<=reg1_i (MTHI) or LO<=reg1_i (MTLO).
  - Strobes arriving in BUSY or DONE are ignored.
- Division by zero: no special handling; whatever div_result_i carries at ready is written (the divider returns 0).
- hi_o/lo_o are registered, with no same-cycle bypass.
- The decoder guarantees at most one op strobe per cycle.

Test Plan:
- DIV reg1=0xFFFFFFF9 (-7), reg2=2: start high from issue until ready, stallreq high across BUSY → HI=0xFFFFFFFF, LO=0xFFFFFFFD; start drops in the ready cycle.
- DIVU reg1=0xFFFFFFFF, reg2=0x10 → LO=0x0FFFFFFF, HI=0x0000000F; div_signed_o=0 and operands stable throughout BUSY even when reg1_i/reg2_i change.
- DIV in progress, flush_i=1 for one cycle at BUSY cycle 10 → annul pulse of 1 cycle, start=0, stallreq=0, HI/LO unchanged, next issue accepted.
- hold_i=1 at ready and for 3 further cycles → state DONE, exactly one HI/LO write, no second start; hold_i=0 → IDLE.
- MTHI 0x12345678 (hold_i=0), then MTLO 0xCAFEBABE with hold_i=1, then again with hold_i=0 → HI=0x12345678; LO changes only on the unheld cycle.
- rst=1 during BUSY cycle 5 → next cycle HI=LO=0, start=0, stallreq=0, annul=0, state IDLE.
